// File: rtl/rv_multdiv_iter_if.sv
// Request/result bus of the iterative RV32M multiply/divide unit.
// A request transfers on an edge where valid_i && ready_o; a result transfers where valid_o && ready_i,
// and result_o holds steady while valid_o && !ready_i; kill_i aborts whatever is in flight.
interface rv_multdiv_iter_if #(parameter int XLEN = 32);
  logic            valid_i;
  logic            ready_o;
  logic [1:0]      operator_i;
  logic [1:0]      signed_mode_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic            kill_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  valid_i, operator_i, signed_mode_i, op_a_i, op_b_i, kill_i, ready_i,
    output ready_o, valid_o, result_o
  );
endinterface

// File: rtl/rv_multdiv_iter.sv
// Iterative RV32M multiply/divide: one shared 64-bit register serves as shift-add accumulator
// or as {partial remainder, dividend/quotient} for restoring division.
module rv_multdiv_iter #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  rv_multdiv_iter_if.slave     md,
  output logic [1:0]           dbg_state_o
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] { MD_OP_MULL = 2'd0, MD_OP_MULH = 2'd1, MD_OP_DIV = 2'd2, MD_OP_REM = 2'd3 } md_op_e;
  typedef enum logic [1:0] { IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3 } state_e;

  state_e              state_q, state_d;
  md_op_e              op_q;
  logic                neg_q;
  logic [CW-1:0]       cnt_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     result_q;

  logic                accept, is_div, sign_a, sign_b, div_zero, div_ovf, special;
  logic [XLEN-1:0]     a_mag, b_mag, special_res, fix_res;
  logic [2*XLEN-1:0]   acc_step, prod_s;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic                div_ge;

  assign md.ready_o  = (state_q == IDLE);
  assign md.valid_o  = (state_q == DONE);
  assign md.result_o = result_q;
  assign dbg_state_o = state_q;

  // Operand conditioning and the two special division cases, all resolved in the accept cycle.
  always_comb begin
    accept   = md.valid_i && md.ready_o && !md.kill_i;
    is_div   = md.operator_i[1];
    sign_a   = md.signed_mode_i[0] & md.op_a_i[XLEN-1];
    sign_b   = md.signed_mode_i[1] & md.op_b_i[XLEN-1];
    a_mag    = sign_a ? -md.op_a_i : md.op_a_i;
    b_mag    = sign_b ? -md.op_b_i : md.op_b_i;
    div_zero = is_div && (md.op_b_i == '0);
    div_ovf  = is_div && (md.signed_mode_i == 2'b11) &&
               (md.op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (md.op_b_i == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = (md.operator_i == MD_OP_DIV) ? '1 : md.op_a_i;
    else if (md.operator_i == MD_OP_DIV)
      special_res = {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration step for each operation class.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (op_q[1])
      acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    else
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
  end

  always_comb begin
    prod_s  = neg_q ? -acc_q : acc_q;
    fix_res = '0;
    case (op_q)
      MD_OP_MULL: fix_res = prod_s[XLEN-1:0];
      MD_OP_MULH: fix_res = prod_s[2*XLEN-1:XLEN];
      MD_OP_DIV:  fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      MD_OP_REM:  fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      default:    fix_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == CW'(ITER-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (md.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (md.kill_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= MD_OP_MULL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q   <= md_op_e'(md.operator_i);
          // The remainder takes the dividend's sign; everything else takes the product of signs.
          neg_q  <= (md.operator_i == MD_OP_REM) ? sign_a : (sign_a ^ sign_b);
          cnt_q  <= '0;
          acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          opnd_q <= is_div ? b_mag : a_mag;
          if (special) result_q <= special_res;
        end
        CALC: begin
          cnt_q <= cnt_q + 1'b1;
          acc_q <= acc_step;
        end
        FIX: result_q <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_multdiv_iter.sv
// Directed bench for rv_multdiv_iter: arithmetic results, latency, special cases, backpressure, kill and reset.
module tb_rv_multdiv_iter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  rv_multdiv_iter_if #(.XLEN(32)) bus ();

  rv_multdiv_iter #(.XLEN(32), .ITER(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .md          (bus),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then scramble the operands to show they are not re-read.
  task automatic issue(input string tag, input logic [1:0] op, input logic [1:0] mode,
                       input logic [31:0] a, input logic [31:0] b);
    check({tag, " ready before"}, 32'(bus.ready_o), 32'd1);
    bus.operator_i    = op;
    bus.signed_mode_i = mode;
    bus.op_a_i        = a;
    bus.op_b_i        = b;
    bus.valid_i       = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.op_a_i  = 32'hDEAD_BEEF;
    bus.op_b_i  = 32'h1234_5678;
    check({tag, " accepted"}, 32'(bus.ready_o), 32'd0);
  endtask

  // Counts edges from the accept edge until valid_o, checks the result, then retires it.
  task automatic wait_result(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int n = 0;
    while (!bus.valid_o && n < 100) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " result"}, bus.result_o, exp_res);
    check({tag, " ready in done"}, 32'(bus.ready_o), 32'd0);
    bus.ready_i = 1'b1;
    tick();
    bus.ready_i = 1'b0;
    check({tag, " valid after take"}, 32'(bus.valid_o), 32'd0);
    check({tag, " ready after take"}, 32'(bus.ready_o), 32'd1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.valid_o) seen++;
    end
    check({tag, " no result"}, 32'(seen), 32'd0);
  endtask

  initial begin
    rst               = 1'b1;
    bus.valid_i       = 1'b1;
    bus.operator_i    = 2'd0;
    bus.signed_mode_i = 2'b00;
    bus.op_a_i        = 32'd7;
    bus.op_b_i        = 32'd6;
    bus.kill_i        = 1'b0;
    bus.ready_i       = 1'b0;
    repeat (3) tick();
    check("reset ready", 32'(bus.ready_o), 32'd1);
    check("reset valid", 32'(bus.valid_o), 32'd0);
    check("reset result", bus.result_o, 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    check("first accept", 32'(bus.ready_o), 32'd0);
    wait_result("mull 7x6", 33, 32'd42);

    issue("mull -3x5", 2'd0, 2'b11, 32'hFFFF_FFFD, 32'd5);
    wait_result("mull -3x5", 33, 32'hFFFF_FFF1);
    issue("mulh", 2'd1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("mulh", 33, 32'h0000_0000);
    issue("mulhu", 2'd1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result("mulhu", 33, 32'hFFFF_FFFE);
    issue("mulhsu", 2'd1, 2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_result("mulhsu", 33, 32'hFFFF_FFFF);

    issue("div -7/2", 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_result("div -7/2", 33, 32'hFFFF_FFFD);
    issue("rem -7/2", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2);
    wait_result("rem -7/2", 33, 32'hFFFF_FFFF);
    issue("divu 100/7", 2'd2, 2'b00, 32'd100, 32'd7);
    wait_result("divu 100/7", 33, 32'd14);
    issue("remu 100/7", 2'd3, 2'b00, 32'd100, 32'd7);
    wait_result("remu 100/7", 33, 32'd2);

    issue("div by 0", 2'd2, 2'b11, 32'd123, 32'd0);
    wait_result("div by 0", 0, 32'hFFFF_FFFF);
    issue("rem by 0", 2'd3, 2'b11, 32'd123, 32'd0);
    wait_result("rem by 0", 0, 32'd123);
    issue("div ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("div ovf", 0, 32'h8000_0000);
    issue("rem ovf", 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("rem ovf", 0, 32'd0);
    issue("divu big", 2'd2, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("divu big", 33, 32'd0);
    issue("remu big", 2'd3, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result("remu big", 33, 32'h8000_0000);

    // Backpressure: result must sit still while the consumer stalls.
    issue("bp", 2'd2, 2'b00, 32'd100, 32'd7);
    for (int i = 0; i < 40 && !bus.valid_o; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check("bp valid held", 32'(bus.valid_o), 32'd1);
      check("bp result held", bus.result_o, 32'd14);
      check("bp ready low", 32'(bus.ready_o), 32'd0);
      tick();
    end
    wait_result("bp release", 0, 32'd14);
    issue("after bp", 2'd0, 2'b00, 32'd3, 32'd5);
    wait_result("after bp", 33, 32'd15);

    // Kill alongside a request in IDLE drops the request.
    bus.operator_i = 2'd0;
    bus.op_a_i     = 32'd2;
    bus.op_b_i     = 32'd2;
    bus.valid_i    = 1'b1;
    bus.kill_i     = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    check("kill idle ready", 32'(bus.ready_o), 32'd1);
    check("kill idle state", 32'(dbg_state), 32'd0);
    watch_quiet("kill idle", 40);

    // Kill while the counter is at 10.
    issue("kill calc", 2'd0, 2'b00, 32'd9, 32'd9);
    repeat (10) tick();
    check("kill calc in calc", 32'(dbg_state), 32'd1);
    bus.kill_i = 1'b1;
    tick();
    bus.kill_i = 1'b0;
    check("kill calc state", 32'(dbg_state), 32'd0);
    check("kill calc valid", 32'(bus.valid_o), 32'd0);
    watch_quiet("kill calc", 40);
    issue("after kill", 2'd0, 2'b00, 32'd3, 32'd5);
    wait_result("after kill", 33, 32'd15);

    // Kill wins over ready_i in DONE.
    issue("kill done", 2'd2, 2'b00, 32'd5, 32'd0);
    check("kill done valid", 32'(bus.valid_o), 32'd1);
    bus.kill_i  = 1'b1;
    bus.ready_i = 1'b1;
    tick();
    bus.kill_i  = 1'b0;
    bus.ready_i = 1'b0;
    check("kill done state", 32'(dbg_state), 32'd0);
    check("kill done valid gone", 32'(bus.valid_o), 32'd0);

    // Reset pulse in the middle of CALC.
    issue("rst calc", 2'd0, 2'b00, 32'd9, 32'd9);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst calc state", 32'(dbg_state), 32'd0);
    check("rst calc valid", 32'(bus.valid_o), 32'd0);
    check("rst calc result", bus.result_o, 32'd0);
    watch_quiet("rst calc", 40);
    issue("after rst", 2'd0, 2'b00, 32'd3, 32'd5);
    wait_result("after rst", 33, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
